if_fetch_stage: RTL and testbench

// Instruction-fetch stage; the upstream end of the IF->ID interface. Owns the PC and the

---
 rtl/if_pkg.sv | 9 +
 rtl/if_next_pc.sv | 39 +++
 rtl/if_fetch_stage.sv | 139 +++++++++++++
 tb/tb_if_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_pkg;
  localparam logic [1:0]  PCSRC_PC4    = 2'b00;
  localparam logic [1:0]  PCSRC_PCIMM  = 2'b01;
  localparam logic [1:0]  PCSRC_REGIMM = 2'b10;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} if_state_t;
endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: resolves ID redirects and picks the value pc_q takes at the next edge.
import if_pkg::*;

module if_next_pc (
  input  if_state_t   i_state,
  input  logic        i_en,
  input  logic        i_ready,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_pc_imm,
  input  logic [31:0] i_reg_imm,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_redir,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_next_pc
);
  // ID operands may be stale while stalled, so a redirect only counts when advancing.
  assign o_redirect = i_en && (i_pcsrc == PCSRC_PCIMM || i_pcsrc == PCSRC_REGIMM);
  assign o_target   = (i_pcsrc == PCSRC_REGIMM) ? i_reg_imm : i_pc_imm;

  always_comb begin
    o_next_pc = i_pc;
    unique case (i_state)
      FETCH: begin
        if (i_ready && o_redirect)  o_next_pc = o_target;
        else if (i_ready && i_en)   o_next_pc = i_pc + 32'd4;
      end
      HOLD: begin
        if (o_redirect)             o_next_pc = o_target;
        else if (i_en)              o_next_pc = i_buf_pc + 32'd4;
      end
      DISCARD: begin
        if (i_ready)                o_next_pc = o_redirect ? o_target : i_redir;
      end
      default:                      o_next_pc = i_pc;
    endcase
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the single-outstanding imem handshake and the IF/ID register.
import if_pkg::*;

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [1:0]  IF_PCsrc_i,
  input  logic [31:0] IF_pcPlusImm_i,
  input  logic [31:0] IF_regPlusImm_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        IMemReady_o,
  output logic [24:0] Instr31_7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_5_o,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o
);
  if_state_t   r_state, w_nstate;
  logic [31:0] r_pc, r_buf, r_buf_pc, r_redir;
  logic [31:0] r_instr, r_pc_o, r_pc4_o;
  logic        r_valid;

  logic        w_redirect, w_load, w_bubble, w_buf_we, w_redir_we;
  logic [31:0] w_target, w_next_pc, w_ld_instr, w_ld_pc;

  if_next_pc u_next_pc (
    .i_state    (r_state),
    .i_en       (en_i),
    .i_ready    (imem_ready_i),
    .i_pcsrc    (IF_PCsrc_i),
    .i_pc_imm   (IF_pcPlusImm_i),
    .i_reg_imm  (IF_regPlusImm_i),
    .i_pc       (r_pc),
    .i_buf_pc   (r_buf_pc),
    .i_redir    (r_redir),
    .o_redirect (w_redirect),
    .o_target   (w_target),
    .o_next_pc  (w_next_pc)
  );

  always_comb begin
    w_nstate   = r_state;
    w_load     = 1'b0;
    w_bubble   = 1'b0;
    w_buf_we   = 1'b0;
    w_redir_we = 1'b0;
    w_ld_instr = imem_rdata_i;
    w_ld_pc    = r_pc;
    unique case (r_state)
      FETCH: begin
        if (imem_ready_i) begin
          if (w_redirect)  w_bubble = 1'b1;
          else if (en_i)   w_load   = 1'b1;
          else begin
            w_buf_we = 1'b1;
            w_nstate = HOLD;
          end
        end else if (w_redirect) begin
          // Request already on the bus: finish it at the old address, remember the target.
          w_bubble   = 1'b1;
          w_redir_we = 1'b1;
          w_nstate   = DISCARD;
        end else if (en_i) begin
          w_bubble = 1'b1;
        end
      end
      HOLD: begin
        w_ld_instr = r_buf;
        w_ld_pc    = r_buf_pc;
        if (en_i) begin
          w_nstate = FETCH;
          if (w_redirect) w_bubble = 1'b1;
          else            w_load   = 1'b1;
        end
      end
      DISCARD: begin
        w_bubble   = en_i;
        w_redir_we = w_redirect;
        if (imem_ready_i) w_nstate = FETCH;
      end
      default: w_nstate = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_buf    <= NOP_INSTR;
      r_buf_pc <= 32'd0;
      r_redir  <= 32'd0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
      r_pc_o   <= 32'd0;
      r_pc4_o  <= 32'd0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_next_pc;
      if (w_buf_we) begin
        r_buf    <= imem_rdata_i;
        r_buf_pc <= r_pc;
      end
      if (w_redir_we) r_redir <= w_target;
      if (w_load) begin
        r_instr <= w_ld_instr;
        r_valid <= 1'b1;
        r_pc_o  <= w_ld_pc;
        r_pc4_o <= w_ld_pc + 32'd4;
      end else if (w_bubble) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_req_o  = (r_state != HOLD);
  assign imem_addr_o = r_pc;
  assign IMemReady_o = r_valid;
  assign Instr31_7_o = r_instr[31:7];
  assign rs1_o       = r_instr[19:15];
  assign rs2_o       = r_instr[24:20];
  assign rd_o        = r_instr[11:7];
  assign op_o        = r_instr[6:0];
  assign funct3_o    = r_instr[14:12];
  assign funct7_5_o  = r_instr[30];
  assign PC_o        = r_pc_o;
  assign pcPlus4_o   = r_pc4_o;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Random + directed bench for if_fetch_stage; a transaction-level model predicts each IF/ID update.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0, en_i = 1'b1, imem_ready_i = 1'b0;
  logic [1:0]  IF_PCsrc_i = 2'b00;
  logic [31:0] IF_pcPlusImm_i = '0, IF_regPlusImm_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, IMemReady_o, funct7_5_o;
  logic [31:0] imem_addr_o, PC_o, pcPlus4_o;
  logic [24:0] Instr31_7_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;

  if_fetch_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .IF_PCsrc_i(IF_PCsrc_i),
    .IF_pcPlusImm_i(IF_pcPlusImm_i), .IF_regPlusImm_i(IF_regPlusImm_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rdata_i(imem_rdata_i), .IMemReady_o(IMemReady_o), .Instr31_7_o(Instr31_7_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .op_o(op_o), .funct3_o(funct3_o),
    .funct7_5_o(funct7_5_o), .PC_o(PC_o), .pcPlus4_o(pcPlus4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  // Model state: where fetching is, whether a fetched word is parked, and a pending wrong-path fetch.
  logic [31:0] m_pc = '0, m_held_pc = '0, m_disc_tgt = '0, m_held_word = '0;
  logic [31:0] m_last_pc = '0, m_last_p4 = '0;
  bit          m_held = 0, m_disc = 0, m_init = 0;
  bit          exp_upd = 0, exp_rst = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_9617;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_valid(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.v = 1'b1; e.instr = instr; e.pc = pc; e.p4 = pc + 32'd4;
    m_last_pc = pc; m_last_p4 = pc + 32'd4;
    q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.v = 1'b0; e.instr = NOP; e.pc = m_last_pc; e.p4 = m_last_p4;
    q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [1:0] src, input logic rdy,
                     input logic [31:0] pimm, input logic [31:0] rimm);
    bit          redir;
    logic [31:0] tgt;
    @(negedge clk_i);
    if (m_init) begin
      chk("imem_req", {31'd0, imem_req_o}, {31'd0, !m_held});
      chk("imem_addr", imem_addr_o, m_pc);
    end
    rst_n_i = rst; en_i = en; IF_PCsrc_i = src; imem_ready_i = rdy;
    IF_pcPlusImm_i = pimm; IF_regPlusImm_i = rimm;
    imem_rdata_i = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;
    redir = en && (src == 2'b01 || src == 2'b10);
    tgt   = (src == 2'b10) ? rimm : pimm;
    exp_rst = !rst;
    exp_upd = rst && en && m_init;
    if (!rst) begin
      m_pc = 32'h0; m_held = 0; m_disc = 0; m_last_pc = 0; m_last_p4 = 0; m_init = 1;
    end else if (m_held) begin
      if (en) begin
        if (redir) begin push_bubble(); m_pc = tgt; end
        else begin push_valid(m_held_word, m_held_pc); m_pc = m_held_pc + 32'd4; end
        m_held = 0;
      end
    end else if (m_disc) begin
      if (en) push_bubble();
      if (redir) m_disc_tgt = tgt;
      if (rdy) begin m_pc = redir ? tgt : m_disc_tgt; m_disc = 0; end
    end else if (rdy) begin
      if (redir) begin push_bubble(); m_pc = tgt; end
      else if (en) begin push_valid(mem_word(m_pc), m_pc); m_pc = m_pc + 32'd4; end
      else begin m_held = 1; m_held_pc = m_pc; m_held_word = mem_word(m_pc); end
    end else begin
      if (redir) begin push_bubble(); m_disc = 1; m_disc_tgt = tgt; end
      else if (en) push_bubble();
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 2'b00, 1, 32'h0, 32'h0);
  endtask

  // Monitor: after every edge that advanced IF/ID, pop the prediction and compare all outputs.
  initial begin
    bit   u, r;
    exp_t e;
    forever begin
      @(posedge clk_i);
      u = exp_upd; r = exp_rst;
      #1;
      if (r) begin
        chk("rst_valid", {31'd0, IMemReady_o}, 32'd0);
        chk("rst_pc", PC_o, 32'd0);
        chk("rst_pc4", pcPlus4_o, 32'd0);
        chk("rst_instr", {Instr31_7_o, op_o}, NOP);
        chk("rst_req_addr", {imem_addr_o[30:0], imem_req_o}, 32'd1);
      end else if (u) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: got update, expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("valid", {31'd0, IMemReady_o}, {31'd0, e.v});
          chk("instr", {Instr31_7_o, op_o}, e.instr);
          chk("fields", {12'd0, rs1_o, rs2_o, rd_o, funct3_o, funct7_5_o},
              {12'd0, e.instr[19:15], e.instr[24:20], e.instr[11:7], e.instr[14:12], e.instr[30]});
          chk("PC_o", PC_o, e.pc);
          chk("pcPlus4", pcPlus4_o, e.p4);
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0]  src;
    logic [31:0] t1, t2;
    cyc(0, 1, 2'b00, 0, 32'h0, 32'h0);
    cyc(0, 1, 2'b00, 0, 32'h0, 32'h0);
    seq(4);                                         // zero-wait stream 0,4,8,c
    for (int i = 0; i < 3; i++) cyc(1, 1, 2'b00, 0, 32'h0, 32'h0);  // miss at 0x10
    seq(2);
    cyc(1, 1, 2'b01, 1, 32'h100, 32'h0);            // taken branch, one bubble
    seq(3);
    cyc(1, 1, 2'b10, 0, 32'h0, 32'h200);            // jalr while pending
    cyc(1, 1, 2'b00, 0, 32'h0, 32'h0);
    cyc(1, 1, 2'b01, 0, 32'h300, 32'h0);            // newer redirect wins
    cyc(1, 1, 2'b00, 1, 32'h0, 32'h0);
    seq(2);
    cyc(1, 0, 2'b00, 1, 32'h0, 32'h0);              // stall on ready -> hold
    cyc(1, 0, 2'b01, 0, 32'h500, 32'h0);            // redirect ignored while stalled
    cyc(1, 1, 2'b00, 0, 32'h0, 32'h0);
    seq(2);
    cyc(1, 1, 2'b01, 1, 32'hFFFF_FFF8, 32'h0);      // wrap past 2^32
    seq(4);
    cyc(1, 1, 2'b00, 0, 32'h0, 32'h0);
    cyc(0, 1, 2'b00, 0, 32'h0, 32'h0);              // reset mid-miss
    seq(2);
    cyc(1, 0, 2'b00, 1, 32'h0, 32'h0);
    cyc(0, 1, 2'b00, 1, 32'h0, 32'h0);              // reset in hold
    seq(2);
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 7);
      src = (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
      t1  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      t2  = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 249) != 0), ($urandom_range(0, 3) != 0), src,
          ($urandom_range(0, 2) != 0), t1, t2);
    end
    cyc(1, 0, 2'b00, 0, 32'h0, 32'h0);
    cyc(1, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
